// File: rtl/button_event_arbiter.sv
// Debounced button levels -> SHORT/LONG/REPEAT events, one pending slot per button,
// round-robin serialised onto a single valid/ready event stream.

module button_press_fsm #(
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_W         = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_lvl,
   output logic       post,
   output logic [1:0] post_type,
   output logic       held
);
   localparam logic [1:0] EVT_SHORT  = 2'b00;
   localparam logic [1:0] EVT_LONG   = 2'b01;
   localparam logic [1:0] EVT_REPEAT = 2'b10;
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PRESS, HOLD} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         held  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         held  <= (state != IDLE);
      end
   end

   // Release wins over a threshold hit in the same cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      post      = 1'b0;
      post_type = EVT_SHORT;
      case (state)
         IDLE: begin
            if (btn_lvl) begin
               state_nxt = PRESS;
               cnt_nxt   = '0;
            end
         end
         PRESS: begin
            if (!btn_lvl) begin
               post      = 1'b1;
               post_type = EVT_SHORT;
               state_nxt = IDLE;
            end else if (cnt == LONG_LAST) begin
               post      = 1'b1;
               post_type = EVT_LONG;
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HOLD: begin
            if (!btn_lvl) begin
               state_nxt = IDLE;
            end else if (cnt == REPEAT_LAST) begin
               post      = 1'b1;
               post_type = EVT_REPEAT;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

module button_event_arbiter #(
   parameter int NUM_BTN       = 4,
   parameter int ID_W          = 2,
   parameter int LONG_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 10000000,
   parameter int CNT_W         = 26
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_lvl,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [ID_W-1:0]    evt_id,
   output logic [1:0]         evt_type,
   output logic [NUM_BTN-1:0] btn_held,
   output logic               evt_drop
);
   localparam int IW = ID_W + 1;

   logic [NUM_BTN-1:0]      post, slot_v, grant, drop_vec;
   logic [NUM_BTN-1:0][1:0] post_type, slot_type;
   logic [ID_W-1:0]         rr, win;
   logic [IW-1:0]           idx;
   logic                    found, load;

   genvar g;
   generate
      for (g = 0; g < NUM_BTN; g++) begin : g_btn
         button_press_fsm #(
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .CNT_W        (CNT_W)
         ) u_fsm (
            .clk      (clk),
            .rst      (rst),
            .btn_lvl  (btn_lvl[g]),
            .post     (post[g]),
            .post_type(post_type[g]),
            .held     (btn_held[g])
         );
         assign drop_vec[g] = post[g] && slot_v[g] && !grant[g];
      end
   endgenerate

   // A slot being granted this cycle can take a new post without loss.
   always_ff @(posedge clk) begin
      if (!rst) begin
         slot_v    <= '0;
         slot_type <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (post[i] && (!slot_v[i] || grant[i])) begin
               slot_v[i]    <= 1'b1;
               slot_type[i] <= post_type[i];
            end else if (grant[i]) begin
               slot_v[i] <= 1'b0;
            end
         end
      end
   end

   assign load = !evt_valid || evt_ready;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         idx = {1'b0, rr} + IW'(k);
         if (idx >= IW'(NUM_BTN)) idx = idx - IW'(NUM_BTN);
         if (!found && slot_v[idx[ID_W-1:0]]) begin
            found = 1'b1;
            win   = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      grant = '0;
      if (load && found) grant[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         evt_valid <= 1'b0;
         evt_id    <= '0;
         evt_type  <= 2'b00;
         evt_drop  <= 1'b0;
         rr        <= '0;
      end else begin
         evt_drop <= |drop_vec;
         if (load) begin
            evt_valid <= found;
            if (found) begin
               evt_id   <= win;
               evt_type <= slot_type[win];
               rr       <= (win == ID_W'(NUM_BTN - 1)) ? '0 : win + ID_W'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: cycle table for short presses and
// round-robin, hand sequences for long/repeat, backpressure, refill and reset.

module tb_button_event_arbiter;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn_lvl = 4'h0;
   logic       evt_ready = 1'b1;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic [1:0] evt_type;
   logic [3:0] btn_held;
   logic       evt_drop;

   button_event_arbiter #(
      .NUM_BTN(4), .ID_W(2), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .btn_lvl(btn_lvl), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_id(evt_id), .evt_type(evt_type),
      .btn_held(btn_held), .evt_drop(evt_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] btn;
      logic       ev;
      logic [1:0] id;
      logic [1:0] ty;
      logic [3:0] held;
   } vec_t;

   typedef struct {
      logic [1:0] id;
      logic [1:0] ty;
      int         cyc;
   } evt_t;

   vec_t vq[$];
   evt_t ev_q[$];
   int   cyc = 0;
   int   drop_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   t0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst && evt_valid && evt_ready) ev_q.push_back('{evt_id, evt_type, cyc});
      if (evt_drop) drop_cnt++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic add(input logic r, input logic [3:0] b, input logic e,
                      input logic [1:0] i, input logic [3:0] h);
      vq.push_back('{r, b, e, i, 2'b00, h});
   endtask

   task automatic do_reset();
      rst = 1'b0; btn_lvl = 4'h0; evt_ready = 1'b1;
      step(2);
      rst = 1'b1;
      ev_q.delete();
      drop_cnt = 0;
   endtask

   task automatic short_press(input int b);
      btn_lvl[b] = 1'b1;
      step(2);
      btn_lvl[b] = 1'b0;
      step(1);
   endtask

   initial begin
      // rst, btn, exp valid, exp id, exp held (rows are applied then checked after the edge)
      add(0, 4'h0, 0, 0, 4'h0); add(0, 4'h0, 0, 0, 4'h0);
      add(1, 4'h2, 0, 0, 4'h0); add(1, 4'h2, 0, 0, 4'h2); add(1, 4'h2, 0, 0, 4'h2);
      add(1, 4'h0, 0, 0, 4'h2); add(1, 4'h0, 1, 1, 4'h0); add(1, 4'h0, 0, 0, 4'h0);
      add(0, 4'h0, 0, 0, 4'h0);
      add(1, 4'hD, 0, 0, 4'h0); add(1, 4'hD, 0, 0, 4'hD); add(1, 4'h0, 0, 0, 4'hD);
      add(1, 4'h0, 1, 0, 4'h0); add(1, 4'h0, 1, 2, 4'h0); add(1, 4'h0, 1, 3, 4'h0);
      add(1, 4'h0, 0, 0, 4'h0);
      add(1, 4'h5, 0, 0, 4'h0); add(1, 4'h0, 0, 0, 4'h5); add(1, 4'h0, 1, 0, 4'h0);
      add(1, 4'h0, 1, 2, 4'h0); add(1, 4'h0, 0, 0, 4'h0);
      add(1, 4'h9, 0, 0, 4'h0); add(1, 4'h0, 0, 0, 4'h9); add(1, 4'h0, 1, 3, 4'h0);
      add(1, 4'h0, 1, 0, 4'h0); add(1, 4'h0, 0, 0, 4'h0);

      #2;
      foreach (vq[i]) begin
         rst = vq[i].rst; btn_lvl = vq[i].btn; evt_ready = 1'b1;
         step(1);
         chk($sformatf("row%0d valid", i), 32'(evt_valid), 32'(vq[i].ev));
         chk($sformatf("row%0d held", i), 32'(btn_held), 32'(vq[i].held));
         chk($sformatf("row%0d drop", i), 32'(evt_drop), 32'(0));
         if (vq[i].ev || !vq[i].rst) begin
            chk($sformatf("row%0d id", i), 32'(evt_id), 32'(vq[i].id));
            chk($sformatf("row%0d type", i), 32'(evt_type), 32'(vq[i].ty));
         end
      end

      // Long press then repeats: button 0 high for 21 sampled edges.
      do_reset();
      btn_lvl = 4'h1;
      step(1);
      t0 = cyc;
      step(14);
      chk("long held", 32'(btn_held[0]), 32'(1));
      step(6);
      btn_lvl = 4'h0;
      step(8);
      chk("long count", 32'(ev_q.size()), 32'(4));
      if (ev_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("long ev%0d id", i), 32'(ev_q[i].id), 32'(0));
            chk($sformatf("long ev%0d type", i), 32'(ev_q[i].ty), (i == 0) ? 32'(1) : 32'(2));
            chk($sformatf("long ev%0d cyc", i), 32'(ev_q[i].cyc - t0), 32'(9 + 4 * i));
         end
      end
      chk("long drop", 32'(drop_cnt), 32'(0));

      // Reset while holding with a REPEAT pending behind a stalled LONG.
      do_reset();
      evt_ready = 1'b0;
      btn_lvl = 4'h1;
      step(14);
      chk("hold stall valid", 32'(evt_valid), 32'(1));
      chk("hold stall type", 32'(evt_type), 32'(1));
      rst = 1'b0;
      step(1);
      chk("rst valid", 32'(evt_valid), 32'(0));
      chk("rst held", 32'(btn_held), 32'(0));
      chk("rst id", 32'(evt_id), 32'(0));
      chk("rst type", 32'(evt_type), 32'(0));
      chk("rst drop", 32'(evt_drop), 32'(0));
      rst = 1'b1; evt_ready = 1'b1;
      ev_q.delete();
      step(1);
      t0 = cyc;
      step(9);
      btn_lvl = 4'h0;
      step(6);
      chk("post-rst count", 32'(ev_q.size()), 32'(1));
      if (ev_q.size() >= 1) begin
         chk("post-rst type", 32'(ev_q[0].ty), 32'(1));
         chk("post-rst cyc", 32'(ev_q[0].cyc - t0), 32'(9));
      end

      // Backpressure: output + slot full, third press is dropped.
      do_reset();
      evt_ready = 1'b0;
      short_press(2);
      short_press(2);
      chk("bp valid", 32'(evt_valid), 32'(1));
      chk("bp id", 32'(evt_id), 32'(2));
      short_press(2);
      step(2);
      chk("bp drop pulses", 32'(drop_cnt), 32'(1));
      chk("bp drop low", 32'(evt_drop), 32'(0));
      evt_ready = 1'b1;
      step(6);
      chk("bp count", 32'(ev_q.size()), 32'(2));
      foreach (ev_q[i]) chk($sformatf("bp ev%0d id", i), 32'(ev_q[i].id), 32'(2));

      // Grant and post land on the same edge: slot refills, nothing lost.
      do_reset();
      evt_ready = 1'b0;
      short_press(1);
      short_press(1);
      btn_lvl[1] = 1'b1;
      step(2);
      btn_lvl[1] = 1'b0;
      evt_ready = 1'b1;
      step(6);
      chk("refill drop", 32'(drop_cnt), 32'(0));
      chk("refill count", 32'(ev_q.size()), 32'(3));
      if (ev_q.size() == 3) begin
         chk("refill gap1", 32'(ev_q[1].cyc - ev_q[0].cyc), 32'(1));
         chk("refill gap2", 32'(ev_q[2].cyc - ev_q[1].cyc), 32'(1));
      end
      foreach (ev_q[i]) chk($sformatf("refill ev%0d id", i), 32'(ev_q[i].id), 32'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
